batt_mon: RTL

Battery monitor that sits between `A2D_Intf` and `piezo` in the Segway top level and replaces the raw single-sample `batt <= threshold` compare. It averages battery conversions over a fixed window and applies hysteresis and a consecutive-window debounce. It drives a clean `batt_low` to the piezo, plus a `batt_crit` level for the balance/power logic. Samples are qualified by the same `vld` strobe that paces the A2D round-robin.

---
 rtl/batt_mon.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/batt_mon.sv
// Battery monitor: windowed average of A2D battery samples, hysteresis and
// consecutive-window debounce into OK/LOW/CRIT. Macro BATT_MON_CRIT_LATCH_EN makes CRIT sticky.
module batt_mon #(
  parameter logic [11:0] LOW_THRESH  = 12'h800,
  parameter logic [11:0] HYST        = 12'h040,
  parameter logic [11:0] CRIT_THRESH = 12'h700,
  parameter int unsigned AVG_LOG2    = 3,
  parameter int unsigned DEBOUNCE    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] batt,
  input  logic        smpl,
  output logic [11:0] batt_avg,
  output logic        avg_vld,
  output logic        batt_low,
  output logic        batt_crit
);

  localparam int unsigned AW     = 12 + AVG_LOG2;
  localparam logic [12:0] OK_LVL = {1'b0, LOW_THRESH} + {1'b0, HYST};
  localparam logic [3:0]  DB     = 4'(DEBOUNCE);

  typedef enum logic [1:0] {ST_OK, ST_LOW, ST_CRIT} state_t;

  logic [AW-1:0]       acc;
  logic [AW-1:0]       sum;
  logic [AVG_LOG2-1:0] cnt;

  state_t     state, state_nxt;
  logic [3:0] dcnt, dcnt_nxt, dcnt_inc, run;
  logic       dir_crit, dir_crit_nxt;
  logic [12:0] avg13;
  logic       low_c, crit_c, ok_c;

  assign sum = acc + {{AVG_LOG2{1'b0}}, batt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      batt_avg <= '1;
      avg_vld  <= 1'b0;
    end else begin
      avg_vld <= 1'b0;
      if (smpl) begin
        if (cnt == '1) begin
          batt_avg <= sum[AW-1:AVG_LOG2];
          acc      <= '0;
          cnt      <= '0;
          avg_vld  <= 1'b1;
        end else begin
          acc <= sum;
          cnt <= cnt + AVG_LOG2'(1);
        end
      end
    end
  end

  assign avg13    = {1'b0, batt_avg};
  assign low_c    = batt_avg <= LOW_THRESH;
  assign crit_c   = batt_avg <= CRIT_THRESH;
  assign ok_c     = avg13 >= OK_LVL;
  assign dcnt_inc = dcnt + 4'd1;

`ifndef BATT_MON_CRIT_LATCH_EN
  localparam logic [12:0] REC_LVL = {1'b0, CRIT_THRESH} + {1'b0, HYST};
  logic rec_c;
  assign rec_c = avg13 >= REC_LVL;
`endif

  always_comb begin
    state_nxt    = state;
    dcnt_nxt     = dcnt;
    dir_crit_nxt = dir_crit;
    run          = dcnt_inc;
    if (avg_vld) begin
      case (state)
        ST_OK: begin
          if (low_c) begin
            if (dcnt_inc == DB) begin
              state_nxt = ST_LOW;
              dcnt_nxt  = '0;
            end else begin
              dcnt_nxt = dcnt_inc;
            end
          end else begin
            dcnt_nxt = '0;
          end
        end
        ST_LOW: begin
          if (crit_c || ok_c) begin
            // a run continues only if it is the same candidate type as before
            run          = (dcnt != '0 && dir_crit == crit_c) ? dcnt_inc : 4'd1;
            dir_crit_nxt = crit_c;
            if (run == DB) begin
              if (crit_c) state_nxt = ST_CRIT;
              else        state_nxt = ST_OK;
              dcnt_nxt = '0;
            end else begin
              dcnt_nxt = run;
            end
          end else begin
            dcnt_nxt = '0;
          end
        end
        ST_CRIT: begin
`ifndef BATT_MON_CRIT_LATCH_EN
          if (rec_c) begin
            if (dcnt_inc == DB) begin
              state_nxt = ST_LOW;
              dcnt_nxt  = '0;
            end else begin
              dcnt_nxt = dcnt_inc;
            end
          end else begin
            dcnt_nxt = '0;
          end
`endif
        end
        default: begin
          state_nxt = ST_OK;
          dcnt_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_OK;
      dcnt      <= '0;
      dir_crit  <= 1'b0;
      batt_low  <= 1'b0;
      batt_crit <= 1'b0;
    end else begin
      state     <= state_nxt;
      dcnt      <= dcnt_nxt;
      dir_crit  <= dir_crit_nxt;
      batt_low  <= (state_nxt != ST_OK);
      batt_crit <= (state_nxt == ST_CRIT);
    end
  end

endmodule
